// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the alu_exec execute/writeback stage.
// Holds the default datapath width, opcode encodings and the FSM state type
// used when the sequential multiplier is built in (ALU_MUL_EN).
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_SLT = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } state_t;

  // True for opcodes that complete in the accept cycle.
  function automatic logic is_single_cycle(input logic [3:0] op);
    return op <= OP_SLT;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: upstream instruction handshake plus register-file write port
// and status flags of the alu_exec stage. The master side issues
// instructions; the slave side (alu_exec) accepts them and writes back.
interface alu_exec_if
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) ();
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [4:0]   rd;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   Rw;
  logic         WrEn;
  logic [W-1:0] busW;
  logic         zf;
  logic         cf;
  logic         vf;
  logic         illegal;

  modport master (
    output in_valid, op, rd, a, b,
    input  in_ready, Rw, WrEn, busW, zf, cf, vf, illegal
  );

  modport slave (
    input  in_valid, op, rd, a, b,
    output in_ready, Rw, WrEn, busW, zf, cf, vf, illegal
  );
endinterface

// File: rtl/alu_exec_mul_seq.sv
// mul_seq: W-iteration shift-add multiplier returning the low W bits of a*b.
// The first partial product is folded into the start cycle so that done
// pulses W cycles after start, leaving the final product in prod.
module mul_seq
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] prod
);
  localparam int CW = $clog2(W);

  logic [W-1:0]  mcand_reg;
  logic [W-1:0]  mplier_reg;
  logic [W-1:0]  acc_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;
  logic          done_reg;

  // One shift-add step per cycle; step 0 happens on start, the last on cnt W-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        acc_reg    <= b[0] ? a : '0;
        mcand_reg  <= a << 1;
        mplier_reg <= b >> 1;
        cnt_reg    <= CW'(1);
        busy_reg   <= 1'b1;
      end else if (busy_reg) begin
        acc_reg    <= acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + CW'(1);
        if (cnt_reg == CW'(W - 1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done = done_reg;
  assign prod = acc_reg;

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute/writeback stage between the register file read ports and
// its write port. Single-cycle ops write back the cycle after accept; with
// ALU_MUL_EN defined, op 10 runs through mul_seq (IDLE -> MUL -> WB).
// Without ALU_MUL_EN, op 10 is treated as illegal and in_ready is always 1.
module alu_exec
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic      clk,
  input  logic      rst,
  alu_exec_if.slave bus
);
  logic         accept;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] sll_s [0:4];
  logic [W-1:0] srl_s [0:4];
  logic [W-1:0] sra_s [0:4];
  logic [W-1:0] alu_res;
  logic         alu_cf;
  logic         alu_vf;

  logic [4:0]   rw_reg, rw_next;
  logic         wren_reg, wren_next;
  logic [W-1:0] busw_reg, busw_next;
  logic         zf_reg, zf_next;
  logic         cf_reg, cf_next;
  logic         vf_reg, vf_next;
  logic         illegal_reg, illegal_next;

`ifdef ALU_MUL_EN
  state_t       state_reg, state_next;
  logic         mul_start;
  logic         mul_done;
  logic [W-1:0] mul_prod;
  logic [4:0]   rd_reg;

  mul_seq #(.W(W)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start),
    .a    (bus.a),
    .b    (bus.b),
    .done (mul_done),
    .prod (mul_prod)
  );

  assign bus.in_ready = (state_reg == IDLE);
`else
  assign bus.in_ready = 1'b1;
`endif

  assign accept = bus.in_valid && bus.in_ready;
  assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff   = {1'b0, bus.a} - {1'b0, bus.b};

  // Log shifter: stage gi shifts by 2**gi when b[gi] is set.
  assign sll_s[0] = bus.a;
  assign srl_s[0] = bus.a;
  assign sra_s[0] = bus.a;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_shift
      localparam int SH = 1 << gi;
      assign sll_s[gi+1] = bus.b[gi] ? (sll_s[gi] << SH) : sll_s[gi];
      assign srl_s[gi+1] = bus.b[gi] ? (srl_s[gi] >> SH) : srl_s[gi];
      assign sra_s[gi+1] = bus.b[gi] ? W'($signed(sra_s[gi]) >>> SH) : sra_s[gi];
    end
  endgenerate

  // Single-cycle result and flag candidates; borrow is the top bit of diff.
  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum[W-1:0];
        alu_cf  = sum[W];
        alu_vf  = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
      end
      OP_SUB: begin
        alu_res = diff[W-1:0];
        alu_cf  = diff[W];
        alu_vf  = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOT:  alu_res = ~bus.a;
      OP_SLL:  alu_res = sll_s[4];
      OP_SRL:  alu_res = srl_s[4];
      OP_SRA:  alu_res = sra_s[4];
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_res = '0;
    endcase
  end

  // Next-state and writeback decode; flags and Rw/busW hold unless written.
  always_comb begin
    rw_next      = rw_reg;
    wren_next    = 1'b0;
    busw_next    = busw_reg;
    zf_next      = zf_reg;
    cf_next      = cf_reg;
    vf_next      = vf_reg;
    illegal_next = 1'b0;
`ifdef ALU_MUL_EN
    state_next   = state_reg;
    mul_start    = 1'b0;
`endif
    if (accept) begin
      if (is_single_cycle(bus.op)) begin
        wren_next = 1'b1;
        rw_next   = bus.rd;
        busw_next = alu_res;
        zf_next   = (alu_res == '0);
        cf_next   = alu_cf;
        vf_next   = alu_vf;
      end
`ifdef ALU_MUL_EN
      else if (bus.op == OP_MUL) begin
        state_next = MUL;
        mul_start  = 1'b1;
      end
`endif
      else begin
        illegal_next = 1'b1;
      end
    end
`ifdef ALU_MUL_EN
    case (state_reg)
      MUL: begin
        if (mul_done) begin
          state_next = WB;
          wren_next  = 1'b1;
          rw_next    = rd_reg;
          busw_next  = mul_prod;
          zf_next    = (mul_prod == '0);
          cf_next    = 1'b0;
          vf_next    = 1'b0;
        end
      end
      WB:      state_next = IDLE;
      default: ;
    endcase
`endif
  end

`ifdef ALU_MUL_EN
  // FSM state and the multiply destination captured at accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      rd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (mul_start) rd_reg <= bus.rd;
    end
  end
`endif

  // Registered write port, flags and illegal pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rw_reg      <= '0;
      wren_reg    <= 1'b0;
      busw_reg    <= '0;
      zf_reg      <= 1'b0;
      cf_reg      <= 1'b0;
      vf_reg      <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      rw_reg      <= rw_next;
      wren_reg    <= wren_next;
      busw_reg    <= busw_next;
      zf_reg      <= zf_next;
      cf_reg      <= cf_next;
      vf_reg      <= vf_next;
      illegal_reg <= illegal_next;
    end
  end

  assign bus.Rw      = rw_reg;
  assign bus.WrEn    = wren_reg;
  assign bus.busW    = busw_reg;
  assign bus.zf      = zf_reg;
  assign bus.cf      = cf_reg;
  assign bus.vf      = vf_reg;
  assign bus.illegal = illegal_reg;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vectors for alu_exec with a scoreboard queue.
// Stimulus pushes the hand-computed expected writeback (or illegal pulse);
// a monitor pops and compares whenever WrEn or illegal is seen.
// MUL vectors run only when ALU_MUL_EN is defined; otherwise op 10 is
// exercised as an illegal opcode.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int W = 16;

  typedef struct {
    bit         ill;
    logic [4:0] rw;
    logic [W-1:0] busw;
    logic       zf;
    logic       cf;
    logic       vf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  logic mzf = 1'b0;
  logic mcf = 1'b0;
  logic mvf = 1'b0;

  always #5 clk = ~clk;

  alu_exec_if #(.W(W)) bus ();

  alu_exec #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Presents one instruction, waits for acceptance and returns #1 after the
  // accepting edge. Pushes the expected response unless push is 0.
  task automatic send(input logic [3:0] op, input logic [4:0] rd,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] res, input logic zf, input logic cf,
                      input logic vf, input bit ill, input bit push);
    exp_t e;
    int n;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.rd = rd;
    bus.a  = a;
    bus.b  = b;
    e.ill  = ill;
    e.rw   = rd;
    e.busw = res;
    if (ill) begin
      e.zf = mzf; e.cf = mcf; e.vf = mvf;
    end else begin
      e.zf = zf; e.cf = cf; e.vf = vf;
      if (push) begin
        mzf = zf; mcf = cf; mvf = vf;
      end
    end
    if (push) expq.push_back(e);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    $display("tx op=%0d rd=%0d a=%04h b=%04h exp=%04h ill=%0d", op, rd, a, b, res, ill);
    if (ill) check("illegal_pulse_timing", 32'(bus.illegal), 32'd1);
    else if (op != OP_MUL) check("wren_next_cycle", 32'(bus.WrEn), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard monitor: compares every output event against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (bus.WrEn || bus.illegal)) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual WrEn=%0d illegal=%0d Rw=%0d busW=%04h required no event",
                   bus.WrEn, bus.illegal, bus.Rw, bus.busW);
        end else begin
          e = expq.pop_front();
          if (e.ill) begin
            check("illegal", 32'(bus.illegal), 32'd1);
            check("illegal_no_write", 32'(bus.WrEn), 32'd0);
            check("illegal_flags_hold", 32'({bus.zf, bus.cf, bus.vf}), 32'({e.zf, e.cf, e.vf}));
          end else begin
            check("wren", 32'(bus.WrEn), 32'd1);
            check("no_illegal_on_write", 32'(bus.illegal), 32'd0);
            check("rw", 32'(bus.Rw), 32'(e.rw));
            check("busw", 32'(bus.busW), 32'(e.busw));
            check("flags_zcv", 32'({bus.zf, bus.cf, bus.vf}), 32'({e.zf, e.cf, e.vf}));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.rd = '0;
    bus.a  = '0;
    bus.b  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({bus.WrEn, bus.Rw, bus.busW, bus.zf, bus.cf, bus.vf, bus.illegal}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_no_wren", 32'(bus.WrEn), 32'd0);

    //   op      rd     a         b         result    z     c     v
    send(OP_ADD, 5'd5, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 0, 1);
    idle(1);
    check("wren_single_pulse", 32'(bus.WrEn), 32'd0);
    check("rw_hold", 32'(bus.Rw), 32'd5);
    check("busw_hold", 32'(bus.busW), 32'h0007);
    send(OP_ADD, 5'd1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 0, 1);
    idle(1);
    send(OP_SUB, 5'd2, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b1, 1'b0, 0, 1);
    idle(1);
    send(OP_SUB, 5'd3, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1);
    idle(1);
    send(OP_SUB, 5'd3, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 0, 1);
    idle(1);

    // back-to-back bursts
    send(OP_AND, 5'd4,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 0, 1);
    send(OP_OR,  5'd6,  16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0, 1'b0, 0, 1);
    send(OP_SRA, 5'd8,  16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0, 1'b0, 0, 1);
    send(OP_XOR, 5'd9,  16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b0, 0, 1);
    send(OP_NOT, 5'd10, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0, 0, 1);
    send(OP_SLL, 5'd11, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b0, 0, 1);
    send(OP_SRL, 5'd12, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 1);
    send(OP_SRL, 5'd13, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 0, 1);
    send(OP_SLT, 5'd14, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 1);
    send(OP_SLT, 5'd15, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1);
    send(OP_ADD, 5'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 1);
    idle(1);

    // illegal opcodes: flags (z=1,c=1,v=0) must hold
    send(4'd12, 5'd7, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 1);
    idle(1);
    check("illegal_one_cycle", 32'(bus.illegal), 32'd0);
    send(4'd15, 5'd7, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 1);
    idle(2);

`ifdef ALU_MUL_EN
    send(OP_MUL, 5'd7, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 1'b0, 0, 1);
    // hold a different instruction valid; it must not be accepted
    bus.in_valid = 1'b1;
    bus.op = OP_ADD;
    bus.a  = 16'h0001;
    bus.b  = 16'h0001;
    k = 1;
    while (!bus.WrEn && k < 40) begin
      check("mul_in_ready_low", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      k++;
    end
    check("mul_latency", 32'(k), 32'd17);
    check("wb_in_ready_low", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("after_wb_in_ready", 32'(bus.in_ready), 32'd1);
    check("after_wb_no_wren", 32'(bus.WrEn), 32'd0);
    send(OP_MUL, 5'd17, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 1);
    idle(20);
    send(OP_MUL, 5'd18, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1);
    idle(20);

    // reset during the multiply: no write, outputs cleared at once
    send(OP_MUL, 5'd19, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, 0, 0);
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midmul_reset_outputs", 32'({bus.WrEn, bus.Rw, bus.busW, bus.zf, bus.cf, bus.vf, bus.illegal}), 32'd0);
`else
    send(OP_MUL, 5'd7, 16'h0012, 16'h0034, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 1);
    idle(1);
    check("mul_off_in_ready", 32'(bus.in_ready), 32'd1);
    idle(1);
    #2;
    rst = 1'b0;
    #1;
    check("reset_outputs_again", 32'({bus.WrEn, bus.Rw, bus.busW, bus.zf, bus.cf, bus.vf, bus.illegal}), 32'd0);
`endif
    mzf = 1'b0; mcf = 1'b0; mvf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    idle(20);
    check("no_stray_write", 32'(bus.WrEn), 32'd0);
    send(OP_ADD, 5'd1, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 0, 1);
    idle(3);

    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
